// File: rtl/prep_timer_counter.sv
// prep_timer_counter: preset/compare timer with prescaler, up/down/one-shot modes, match pulse and sticky wrap flag
module prep_timer_counter #(
  parameter int WIDTH      = 8,
  parameter int PRESCALE_W = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_en,
  input  logic                  i_sel,
  input  logic                  i_ldpre,
  input  logic                  i_ldcomp,
  input  logic [1:0]            i_mode,
  input  logic                  i_start,
  input  logic                  i_clr_ovf,
  input  logic [PRESCALE_W-1:0] i_prescale,
  input  logic [WIDTH-1:0]      i_data1,
  input  logic [WIDTH-1:0]      i_data2,
  output logic [WIDTH-1:0]      o_data0,
  output logic                  o_match,
  output logic                  o_running,
  output logic                  o_ovf
);
  localparam logic [1:0] MODE_ONESHOT = 2'b01;
  localparam logic [1:0] MODE_DOWN    = 2'b10;
  logic [WIDTH-1:0]      r_data0, r_pre, r_cmp;
  logic [PRESCALE_W-1:0] r_pcnt;
  logic                  r_match, r_running, r_ovf;
  logic                  w_oneshot, w_down, w_gate, w_tick, w_hit, w_wrap;
  logic [WIDTH-1:0]      w_next;
  assign w_oneshot = i_mode == MODE_ONESHOT;
  assign w_down    = i_mode == MODE_DOWN;
  assign w_gate    = i_en & (~w_oneshot | r_running);
  // >= rather than == so lowering the divisor below the running count ticks at once
  assign w_tick    = w_gate & (r_pcnt >= i_prescale);
  assign w_hit     = r_data0 == r_cmp;
  assign w_wrap    = w_tick & ~w_hit & (w_down ? r_data0 == '0 : &r_data0);
  assign w_next    = w_hit ? (i_sel ? i_data1 : r_pre) : w_down ? r_data0 - WIDTH'(1) : r_data0 + WIDTH'(1);
  assign o_data0   = r_data0;
  assign o_match   = r_match;
  assign o_running = r_running;
  assign o_ovf     = r_ovf;
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_data0   <= '0;
      r_pre     <= '0;
      r_cmp     <= '0;
      r_pcnt    <= '0;
      r_match   <= 1'b0;
      r_running <= 1'b1;
      r_ovf     <= 1'b0;
    end else begin
      if (i_ldpre) r_pre <= i_data2;
      if (i_ldcomp) r_cmp <= i_data2;
      r_pcnt  <= (i_start || w_tick) ? '0 : w_gate ? r_pcnt + PRESCALE_W'(1) : r_pcnt;
      if (w_tick) r_data0 <= w_next;
      r_match <= w_tick & w_hit;
      // a re-arm outranks the one-shot's own disarm on the same edge
      if (i_start && w_oneshot) r_running <= 1'b1;
      else if (w_tick && w_hit && w_oneshot) r_running <= 1'b0;
      r_ovf   <= w_wrap | (r_ovf & ~i_clr_ovf);
    end
  end
endmodule

// File: tb/tb_prep_timer_counter.sv
// tb_prep_timer_counter: directed vectors against an arithmetic model plus hand-computed literal expectations
module tb_prep_timer_counter;
  logic       clk = 1'b0;
  logic       rst_n, en, sel, ldpre, ldcomp, start, clr_ovf;
  logic [1:0] mode;
  logic [3:0] prescale;
  logic [7:0] data1, data2;
  logic [7:0] o_data0;
  logic       o_match, o_running, o_ovf;
  int n_vec = 0;
  int n_err = 0;
  logic [7:0] m_d = 0, m_pre = 0, m_cmp = 0;
  logic       m_match = 0, m_run = 1, m_ovf = 0;
  int         m_pc = 0;
  prep_timer_counter #(.WIDTH(8), .PRESCALE_W(4)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_sel(sel), .i_ldpre(ldpre),
    .i_ldcomp(ldcomp), .i_mode(mode), .i_start(start), .i_clr_ovf(clr_ovf),
    .i_prescale(prescale), .i_data1(data1), .i_data2(data2),
    .o_data0(o_data0), .o_match(o_match), .o_running(o_running), .o_ovf(o_ovf)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [7:0] got, input logic [7:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, got, exp);
    end
  endtask
  task automatic model_reset();
    m_d = 0; m_pre = 0; m_cmp = 0; m_pc = 0; m_match = 0; m_run = 1; m_ovf = 0;
  endtask
  task automatic model_step();
    logic [7:0] nd;
    logic       nr, no;
    bit         gate, tick;
    gate = en && (mode != 2'b01 || m_run);
    tick = gate && (m_pc >= int'(prescale));
    nd = m_d;
    nr = m_run;
    no = clr_ovf ? 1'b0 : m_ovf;
    m_match = 0;
    if (tick) begin
      if (m_d == m_cmp) begin
        nd = sel ? data1 : m_pre;
        m_match = 1;
        if (mode == 2'b01) nr = 0;
      end else if (mode == 2'b10) begin
        if (m_d == 0) no = 1;
        nd = 8'((int'(m_d) + 255) % 256);
      end else begin
        if (m_d == 255) no = 1;
        nd = 8'((int'(m_d) + 1) % 256);
      end
    end
    if (start && mode == 2'b01) nr = 1;
    m_pc = (start || tick) ? 0 : gate ? m_pc + 1 : m_pc;
    if (ldpre) m_pre = data2;
    if (ldcomp) m_cmp = data2;
    m_d = nd;
    m_run = nr;
    m_ovf = no;
  endtask
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) model_reset();
    else model_step();
    #1;
    chk("data0", o_data0, m_d);
    chk("match", {7'b0, o_match}, {7'b0, m_match});
    chk("running", {7'b0, o_running}, {7'b0, m_run});
    chk("ovf", {7'b0, o_ovf}, {7'b0, m_ovf});
  end
  task automatic lit(input logic [7:0] ed, input logic em, input logic er, input logic eo);
    chk("lit_data0", o_data0, ed);
    chk("lit_match", {7'b0, o_match}, {7'b0, em});
    chk("lit_running", {7'b0, o_running}, {7'b0, er});
    chk("lit_ovf", {7'b0, o_ovf}, {7'b0, eo});
  endtask
  task automatic cyc(input logic [7:0] ed, input logic em, input logic er, input logic eo);
    @(posedge clk);
    #2;
    lit(ed, em, er, eo);
  endtask
  task automatic do_reset();
    @(negedge clk);
    rst_n = 0;
    @(negedge clk);
    rst_n = 1;
  endtask
  logic [7:0] e1_d [10] = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd2, 8'd3, 8'd4, 8'd5, 8'd2};
  logic       e1_m [10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
  initial begin
    rst_n = 0; en = 0; sel = 0; ldpre = 0; ldcomp = 0; start = 0; clr_ovf = 0;
    mode = 2'b00; prescale = 0; data1 = 0; data2 = 0;
    cyc(8'h00, 0, 1, 0);
    // up-reload, PREP-compatible sequence
    @(negedge clk); rst_n = 1; ldcomp = 1; data2 = 8'd5; sel = 1; data1 = 8'd2;
    cyc(8'h00, 0, 1, 0);
    @(negedge clk); ldcomp = 0; en = 1;
    for (int i = 0; i < 10; i++) cyc(e1_d[i], e1_m[i], 1, 0);
    // prescale by 3, enable freeze
    @(negedge clk); prescale = 4'd2;
    cyc(8'd2, 0, 1, 0); cyc(8'd2, 0, 1, 0); cyc(8'd3, 0, 1, 0);
    cyc(8'd3, 0, 1, 0); cyc(8'd3, 0, 1, 0);
    @(negedge clk); en = 0;
    for (int i = 0; i < 4; i++) cyc(8'd3, 0, 1, 0);
    @(negedge clk); en = 1;
    cyc(8'd4, 0, 1, 0);
    // one-shot
    @(negedge clk); en = 0; prescale = 0; mode = 2'b01;
    do_reset();
    ldpre = 1; data2 = 8'h10;
    cyc(8'h00, 0, 1, 0);
    @(negedge clk); ldpre = 0; ldcomp = 1; data2 = 8'd3;
    cyc(8'h00, 0, 1, 0);
    @(negedge clk); ldcomp = 0; en = 1; sel = 0;
    cyc(8'd1, 0, 1, 0); cyc(8'd2, 0, 1, 0); cyc(8'd3, 0, 1, 0);
    cyc(8'h10, 1, 0, 0); cyc(8'h10, 0, 0, 0); cyc(8'h10, 0, 0, 0);
    @(negedge clk); start = 1;
    cyc(8'h10, 0, 1, 0);
    @(negedge clk); start = 0;
    cyc(8'h11, 0, 1, 0); cyc(8'h12, 0, 1, 0);
    // down-reload with wrap and clear
    @(negedge clk); en = 0; mode = 2'b10;
    do_reset();
    ldpre = 1; data2 = 8'h08;
    cyc(8'h00, 0, 1, 0);
    @(negedge clk); ldpre = 0; en = 1; sel = 1; data1 = 8'd2; ldcomp = 1; data2 = 8'hF0;
    cyc(8'd2, 1, 1, 0);
    @(negedge clk); ldcomp = 0; sel = 0;
    cyc(8'd1, 0, 1, 0); cyc(8'd0, 0, 1, 0); cyc(8'hFF, 0, 1, 1);
    for (int v = 8'hFE; v >= 8'hF0; v--) cyc(8'(v), 0, 1, 1);
    cyc(8'h08, 1, 1, 1);
    @(negedge clk); clr_ovf = 1;
    cyc(8'd7, 0, 1, 0);
    @(negedge clk); clr_ovf = 0;
    for (int v = 6; v >= 0; v--) cyc(8'(v), 0, 1, 0);
    @(negedge clk); clr_ovf = 1;
    cyc(8'hFF, 0, 1, 1);
    @(negedge clk); clr_ovf = 0;
    // compare load on the edge that matches the old compare
    @(negedge clk); en = 0; mode = 2'b00;
    do_reset();
    ldcomp = 1; data2 = 8'd4; sel = 1; data1 = 8'd1;
    cyc(8'h00, 0, 1, 0);
    @(negedge clk); ldcomp = 0; en = 1;
    for (int v = 1; v <= 4; v++) cyc(8'(v), 0, 1, 0);
    @(negedge clk); ldcomp = 1; data2 = 8'd7;
    cyc(8'd1, 1, 1, 0);
    @(negedge clk); ldcomp = 0;
    for (int v = 2; v <= 7; v++) cyc(8'(v), 0, 1, 0);
    cyc(8'd1, 1, 1, 0);
    // asynchronous reset mid-count
    @(negedge clk); mode = 2'b10; ldcomp = 1; data2 = 8'h30;
    cyc(8'd0, 0, 1, 0);
    @(negedge clk); ldcomp = 0;
    cyc(8'hFF, 0, 1, 1);
    repeat (204) @(posedge clk);
    #2;
    lit(8'h33, 0, 1, 1);
    @(negedge clk); en = 0;
    #2 rst_n = 0;
    #1 lit(8'h00, 0, 1, 0);
    @(negedge clk); rst_n = 1;
    cyc(8'h00, 0, 1, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
